// File: rtl/burst_detector_param.sv
// burst_detector_param
//
// Watches a serial bit stream and flags "bursts". A burst is declared once
// ONES_REQ one-samples have been seen during acquisition (with up to
// ZEROS_MAX zero-samples, not necessarily consecutive, tolerated along the
// way). An active burst survives runs of up to GAP_MAX consecutive zeros and
// terminates on the next zero after that. All outputs are decoded from
// registers, so there is no combinational path from dataIn.
//
// Optional feature: define BURST_DETECTOR_LEN_COUNT_EN to build the burst
// length counter (lenOut/lenValid/lenSat). Without it those outputs are 0.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - asynchronous, active-high reset
//   dataIn   - serial sample, taken on every rising clk edge
//   begP     - high while a burst is active (including tolerated gaps)
//   endP     - one-cycle pulse when a burst terminates
//   lenOut   - begP-high cycle count of the last completed burst
//   lenValid - one-cycle pulse with endP, marks lenOut as updated
//   lenSat   - lenOut saturated at 2^LEN_W-1 for the last burst
module burst_detector_param #(
  parameter int ONES_REQ  = 4,
  parameter int ZEROS_MAX = 3,
  parameter int GAP_MAX   = 1,
  parameter int LEN_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dataIn,
  output logic             begP,
  output logic             endP,
  output logic [LEN_W-1:0] lenOut,
  output logic             lenValid,
  output logic             lenSat
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACQ    = 3'd1,
    ACTIVE = 3'd2,
    HOLD   = 3'd3,
    END    = 3'd4
  } stateT;

  // onesCnt is widened by one bit for the compare so ONES_REQ=255 works.
  localparam logic [8:0] ONES_TGT = 9'(ONES_REQ);
  localparam logic [7:0] ZEROS_TGT = 8'(ZEROS_MAX);
  localparam logic [7:0] GAP_TGT = 8'(GAP_MAX);

  stateT      state, stateNext;
  logic [7:0] onesCnt, onesNext;
  logic [7:0] zerosCnt, zerosNext;
  logic [7:0] gapCnt, gapNext;

  // State and acquisition/gap counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      onesCnt  <= '0;
      zerosCnt <= '0;
      gapCnt   <= '0;
    end else begin
      state    <= stateNext;
      onesCnt  <= onesNext;
      zerosCnt <= zerosNext;
      gapCnt   <= gapNext;
    end
  end

  // Next-state and counter update. Any encoding outside the five legal
  // states falls into the default branch and returns to IDLE.
  always_comb begin
    stateNext = state;
    onesNext  = onesCnt;
    zerosNext = zerosCnt;
    gapNext   = gapCnt;
    case (state)
      IDLE: begin
        if (dataIn) begin
          stateNext = ACQ;
          onesNext  = 8'd1;
          zerosNext = 8'd0;
        end
      end
      ACQ: begin
        if (dataIn) begin
          if (({1'b0, onesCnt} + 9'd1) == ONES_TGT) begin
            stateNext = ACTIVE;
            onesNext  = 8'd0;
            zerosNext = 8'd0;
          end else begin
            onesNext = onesCnt + 8'd1;
          end
        end else begin
          if (zerosCnt == ZEROS_TGT) begin
            stateNext = IDLE;
            onesNext  = 8'd0;
            zerosNext = 8'd0;
          end else begin
            zerosNext = zerosCnt + 8'd1;
          end
        end
      end
      ACTIVE: begin
        gapNext = 8'd0;
        if (!dataIn) begin
          if (GAP_MAX == 0) begin
            stateNext = END;
          end else begin
            stateNext = HOLD;
            gapNext   = 8'd1;
          end
        end
      end
      HOLD: begin
        if (dataIn) begin
          stateNext = ACTIVE;
          gapNext   = 8'd0;
        end else if (gapCnt == GAP_TGT) begin
          stateNext = END;
          gapNext   = 8'd0;
        end else begin
          gapNext = gapCnt + 8'd1;
        end
      end
      END: begin
        gapNext = 8'd0;
        if (dataIn) begin
          stateNext = ACQ;
          onesNext  = 8'd1;
          zerosNext = 8'd0;
        end else begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        onesNext  = 8'd0;
        zerosNext = 8'd0;
        gapNext   = 8'd0;
      end
    endcase
  end

  // Moore outputs straight from the state register.
  assign begP = (state == ACTIVE) || (state == HOLD);
  assign endP = (state == END);

`ifdef BURST_DETECTOR_LEN_COUNT_EN
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  logic [LEN_W-1:0] lenCnt, lenInc;
  logic             satFlag, satInc, lenAtMax;

  // lenInc/satInc are the count including the current begP cycle, so the
  // value latched when entering END covers the final HOLD/ACTIVE cycle too.
  always_comb begin
    lenAtMax = (lenCnt == LEN_MAX);
    lenInc   = lenAtMax ? lenCnt : lenCnt + LEN_W'(1);
    satInc   = satFlag | lenAtMax;
  end

  // Running length count plus the latched result of the last burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lenCnt  <= '0;
      satFlag <= 1'b0;
      lenOut  <= '0;
      lenSat  <= 1'b0;
    end else begin
      if ((state == ACQ) && (stateNext == ACTIVE)) begin
        lenCnt  <= '0;
        satFlag <= 1'b0;
      end else if (begP) begin
        lenCnt  <= lenInc;
        satFlag <= satInc;
      end
      if (begP && (stateNext == END)) begin
        lenOut <= lenInc;
        lenSat <= satInc;
      end
    end
  end

  assign lenValid = endP;
`else
  assign lenOut   = '0;
  assign lenValid = 1'b0;
  assign lenSat   = 1'b0;
`endif

endmodule

// File: tb/tb_burst_detector_param.sv
// tb_burst_detector_param
//
// Directed testbench for burst_detector_param. A default-parameter instance
// and a LEN_W=3 instance share clk, reset and dataIn. Each vector is a
// string with character i holding the sample for cycle i, alongside the
// hand-derived begP/endP expectations for that same cycle.
module tb_burst_detector_param;

`ifdef BURST_DETECTOR_LEN_COUNT_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       dataIn;
  logic       begP, endP, lenValid, lenSat;
  logic [7:0] lenOut;
  logic       begP3, endP3, lenValid3, lenSat3;
  logic [2:0] lenOut3;

  int checks;
  int errors;

  burst_detector_param dut (
    .clk(clk),
    .reset(reset),
    .dataIn(dataIn),
    .begP(begP),
    .endP(endP),
    .lenOut(lenOut),
    .lenValid(lenValid),
    .lenSat(lenSat)
  );

  burst_detector_param #(.LEN_W(3)) dut3 (
    .clk(clk),
    .reset(reset),
    .dataIn(dataIn),
    .begP(begP3),
    .endP(endP3),
    .lenOut(lenOut3),
    .lenValid(lenValid3),
    .lenSat(lenSat3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drives one vector. At each falling edge the outputs for cycle i are
  // checked and then sample i is presented for the next rising edge.
  // idleCycle >= 0 additionally checks the FSM is in IDLE in that cycle.
  task automatic applyStimulus(input string tag, input string din,
                               input string expBeg, input string expEnd,
                               input int idleCycle);
    logic eb, ee;
    for (int i = 0; i < din.len(); i++) begin
      @(negedge clk);
      eb = (expBeg[i] == "1");
      ee = (expEnd[i] == "1");
      checkOutput($sformatf("%s_beg%0d", tag, i), 32'(begP), 32'(eb));
      checkOutput($sformatf("%s_end%0d", tag, i), 32'(endP), 32'(ee));
      checkOutput($sformatf("%s_val%0d", tag, i), 32'(lenValid),
                  32'(ee & LEN_EN));
      checkOutput($sformatf("%s_beg3_%0d", tag, i), 32'(begP3), 32'(eb));
      checkOutput($sformatf("%s_end3_%0d", tag, i), 32'(endP3), 32'(ee));
      if (i == idleCycle)
        checkOutput($sformatf("%s_idle%0d", tag, i), 32'(int'(dut.state)), 32'd0);
      dataIn = (din[i] == "1");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    dataIn = 1'b0;

    // Reset state.
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_beg", 32'(begP), 32'd0);
    checkOutput("rst_end", 32'(endP), 32'd0);
    checkOutput("rst_len", 32'(lenOut), 32'd0);
    checkOutput("rst_val", 32'(lenValid), 32'd0);
    checkOutput("rst_sat", 32'(lenSat), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic burst: begP cycles 4..7, endP cycle 8, length 4.
    applyStimulus("basic", "1111110000", "0000111100", "0000000010", -1);
    checkOutput("basic_len", 32'(lenOut), LEN_EN ? 32'd4 : 32'd0);
    checkOutput("basic_sat", 32'(lenSat), 32'd0);

    // Interleaved zeros during acquisition still reach ONES_REQ.
    applyStimulus("interl", "10101010000", "00000001100", "00000000010", -1);
    checkOutput("interl_len", 32'(lenOut), LEN_EN ? 32'd2 : 32'd0);

    // Four zeros abort acquisition: IDLE in cycle 5, no burst afterwards.
    applyStimulus("abort", "100001110000", "000000000000", "000000000000", 5);

    // Single zero is bridged, two consecutive zeros end the burst.
    applyStimulus("gap", "111110110000", "000011111100", "000000000010", -1);
    checkOutput("gap_len", 32'(lenOut), LEN_EN ? 32'd6 : 32'd0);

    // END followed by 1 goes straight back into acquisition.
    applyStimulus("rearm", "11110011110000", "00001100001100",
                  "00000010000010", 13);
    checkOutput("rearm_len", 32'(lenOut), LEN_EN ? 32'd2 : 32'd0);

    // Ten begP cycles: LEN_W=3 saturates at 7, LEN_W=8 reports 10.
    applyStimulus("sat", "111111111111000", "000011111111110",
                  "000000000000001", -1);
    checkOutput("sat_len3", 32'(lenOut3), LEN_EN ? 32'd7 : 32'd0);
    checkOutput("sat_sat3", 32'(lenSat3), LEN_EN ? 32'd1 : 32'd0);
    checkOutput("sat_val3", 32'(lenValid3), LEN_EN ? 32'd1 : 32'd0);
    checkOutput("sat_len8", 32'(lenOut), LEN_EN ? 32'd10 : 32'd0);
    checkOutput("sat_sat8", 32'(lenSat), 32'd0);

    // Reset mid-burst: begP drops at once, no endP/lenValid afterwards.
    applyStimulus("midrst", "111111", "000011", "000000", -1);
    #1 reset = 1'b1;
    #1;
    checkOutput("midrst_beg", 32'(begP), 32'd0);
    checkOutput("midrst_end", 32'(endP), 32'd0);
    checkOutput("midrst_len", 32'(lenOut), 32'd0);
    checkOutput("midrst_sat3", 32'(lenSat3), 32'd0);
    dataIn = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    applyStimulus("postrst", "00000", "00000", "00000", 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/burst_detector_param.md
BURST_DETECTOR_PARAM -- requirements
Module: burst_detector_param

Interface
REQ-001 The module SHALL have parameter ONES_REQ, default 4, meaning the number of 1 samples required to declare a burst start (legal range 2..255).
REQ-002 The module SHALL have parameter ZEROS_MAX, default 3, meaning the number of 0 samples tolerated during acquisition before it aborts (legal range 0..255).
REQ-003 The module SHALL have parameter GAP_MAX, default 1, meaning the number of consecutive 0 samples tolerated inside an active burst (legal range 0..255).
REQ-004 The module SHALL have parameter LEN_W, default 8, meaning the width of the burst-length counter (legal range 2..32).
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: the reset, asynchronous and active-high.
REQ-007 The module SHALL have port dataIn, input, 1 bit: the serial data sample, taken on every clk rising edge.
REQ-008 The module SHALL have port begP, output, 1 bit: high while a burst is active, including tolerated gaps.
REQ-009 The module SHALL have port endP, output, 1 bit: a one-cycle pulse on burst termination.
REQ-010 The module SHALL have port lenOut, output, LEN_W bits: the begP-high cycle count of the last completed burst.
REQ-011 The module SHALL have port lenValid, output, 1 bit: a one-cycle pulse, coincident with endP, marking lenOut as updated.
REQ-012 The module SHALL have port lenSat, output, 1 bit: high when the latched lenOut saturated.

Function
REQ-013 The module SHALL implement a Moore FSM with states IDLE, ACQ, ACTIVE, HOLD and END, plus counters onesCnt, zerosCnt and gapCnt.
REQ-014 In IDLE, the module SHALL go to ACQ with onesCnt=1 and zerosCnt=0 on dataIn=1, and stay in IDLE on dataIn=0.
REQ-015 In ACQ on dataIn=1, the module SHALL go to ACTIVE if onesCnt+1==ONES_REQ; otherwise it SHALL increment onesCnt and stay in ACQ.
REQ-016 In ACQ on dataIn=0, the module SHALL go to IDLE if zerosCnt==ZEROS_MAX; otherwise it SHALL increment zerosCnt and stay in ACQ; onesCnt is kept, the zeros need not be consecutive.
REQ-017 In ACTIVE, the module SHALL stay in ACTIVE on dataIn=1; on dataIn=0 it SHALL go to END if GAP_MAX==0, else to HOLD with gapCnt=1.
REQ-018 In HOLD, the module SHALL go to ACTIVE and clear gapCnt on dataIn=1; on dataIn=0 it SHALL go to END if gapCnt==GAP_MAX, else increment gapCnt.
REQ-019 In END, the module SHALL go to ACQ with onesCnt=1 and zerosCnt=0 on dataIn=1, and go to IDLE on dataIn=0; END lasts exactly one cycle.
REQ-020 The module SHALL decode begP=(state==ACTIVE or HOLD) and endP=(state==END) directly from the state register, with no combinational path from dataIn.
REQ-021 Latency: begP SHALL rise in the cycle after the ONES_REQth 1 is sampled, and endP SHALL rise in the cycle after the terminating 0 is sampled.
REQ-022 An illegal or unreachable state encoding SHALL recover to IDLE on the next clock.
REQ-023 The length counter SHALL clear on entry to ACTIVE from ACQ and increment on every cycle with begP=1.
REQ-024 The length counter SHALL saturate at 2^LEN_W-1 and set an internal sat flag, with no wrap-around.
REQ-025 On entry to END, lenOut SHALL latch the count and lenSat SHALL latch the sat flag; both SHALL hold until the next END.

Reset
REQ-026 While reset=1, the module SHALL force state=IDLE, all counters to 0, begP=0, endP=0, lenOut=0, lenValid=0 and lenSat=0, asynchronously.
REQ-027 Reset asserted mid-burst SHALL abort the burst without producing an endP or lenValid pulse.
REQ-028 After reset is released, the first dataIn sample SHALL be taken on the next clk rising edge.

Configuration
REQ-029 With macro BURST_DETECTOR_LEN_COUNT_EN defined, the length counter, lenOut, lenValid and lenSat SHALL be implemented as specified in REQ-023 to REQ-025.
REQ-030 Without BURST_DETECTOR_LEN_COUNT_EN, the length counter SHALL be omitted, lenOut, lenValid and lenSat SHALL be tied to 0, and begP/endP behaviour SHALL be unchanged.

Verification (default parameters, macro defined; cycle 0 = first sample)
REQ-031 The bench SHALL cover: dataIn 1,1,1,1,1,1,0,0 -> begP=1 in cycles 4..7, endP=1 in cycle 8 only, lenValid=1 in cycle 8 with lenOut=4, lenSat=0.
REQ-032 The bench SHALL cover: dataIn 1,0,1,0,1,0,1 -> begP rises in cycle 7; and dataIn 1,0,0,0,0,1,1,1 -> no begP, with the FSM in IDLE at cycle 5.
REQ-033 The bench SHALL cover: an active burst with a single 0 between 1s -> begP stays high through the gap with no endP; two consecutive 0s -> endP.
REQ-034 The bench SHALL cover: END followed by dataIn=1 -> ACQ with onesCnt=1, and three further 1s -> begP again without passing through IDLE.
REQ-035 The bench SHALL cover: LEN_W=3 with a 10-cycle begP burst -> lenOut=7 and lenSat=1; and reset=1 asserted mid-burst -> begP=0 immediately, with no endP.
